// File: rtl/common_apb3_cdc_regbank.sv
// ============================================================================
// Module   : common_apb3_cdc_regbank
// Function : APB3 register bank; RW control regs delivered to cross_clk via a
//            toggle req/ack handshake, RO status regs synchronised into clk.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module common_apb3_cdc_regbank #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_WR_REG  = 5,
  parameter int NUM_RD_REG  = 6,
  parameter int RD_BASE     = 5,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] WR_RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             cross_clk,
  input  logic [ADDR_WIDTH-1:0]            PADDR,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PWRITE,
  input  logic [DATA_WIDTH-1:0]            PWDATA,
  output logic                             PREADY,
  output logic [DATA_WIDTH-1:0]            PRDATA,
  output logic                             PSLVERROR,
  input  logic [NUM_RD_REG*DATA_WIDTH-1:0] data_in,
  output logic [NUM_WR_REG*DATA_WIDTH-1:0] data_out,
  output logic [NUM_WR_REG-1:0]            data_upd,
  output logic                             wr_pending
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int WIDX_W = (NUM_WR_REG > 1) ? $clog2(NUM_WR_REG) : 1;
  localparam logic [IDX_W-1:0] WR_END = IDX_W'(NUM_WR_REG);
  localparam logic [IDX_W-1:0] RD_LO  = IDX_W'(RD_BASE);
  localparam logic [IDX_W-1:0] RD_HI  = IDX_W'(RD_BASE + NUM_RD_REG);

  if (RD_BASE < NUM_WR_REG) begin : g_bad_rd_base
    $error("RD_BASE overlaps the control register range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ACCESS  = 2'd2,
    S_WR_WAIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_WR_REG-1:0][DATA_WIDTH-1:0]   shadow_q;
  logic [WIDX_W-1:0]                       wr_idx_q;
  logic                                    req_q;
  logic                                    wr_pending_q;
  logic [SYNC_STAGES-1:0]                  ack_sync_q;
  logic [SYNC_STAGES-1:0][NUM_RD_REG*DATA_WIDTH-1:0] status_q;

  logic [IDX_W-1:0] idx;
  logic             in_wr, in_rd, acc_err;
  logic             wr_start, wr_done, ack_done;

  assign idx     = PADDR[ADDR_WIDTH-1:2];
  assign in_wr   = idx < WR_END;
  assign in_rd   = (idx >= RD_LO) && (idx < RD_HI);
  assign acc_err = (PADDR[1:0] != 2'b00) || !(in_wr || in_rd) || (PWRITE && in_rd);
  // req was toggled on WR_WAIT entry, so equality means the ack has come back
  assign ack_done = (ack_sync_q[SYNC_STAGES-1] == req_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    PREADY    = 1'b0;
    PSLVERROR = 1'b0;
    wr_start  = 1'b0;
    wr_done   = 1'b0;
    case (state_q)
      S_IDLE:  if (PSEL && !PENABLE) state_d = S_SETUP;
      S_SETUP: state_d = (PSEL && PENABLE) ? S_ACCESS : S_IDLE;
      S_ACCESS: begin
        if (PWRITE && !acc_err) begin
          wr_start = 1'b1;
          state_d  = S_WR_WAIT;
        end else begin
          PREADY    = 1'b1;
          PSLVERROR = acc_err;
          state_d   = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (ack_done) begin
          PREADY  = 1'b1;
          wr_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PRDATA = '0;
    if (state_q == S_ACCESS && !PWRITE && !acc_err) begin
      for (int k = 0; k < NUM_WR_REG; k++)
        if (idx == IDX_W'(k)) PRDATA = shadow_q[k];
      for (int k = 0; k < NUM_RD_REG; k++)
        if (idx == IDX_W'(RD_BASE + k))
          PRDATA = status_q[SYNC_STAGES-1][k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q     <= {NUM_WR_REG{WR_RESET_VAL}};
      wr_idx_q     <= '0;
      req_q        <= 1'b0;
      wr_pending_q <= 1'b0;
    end else if (wr_start) begin
      for (int k = 0; k < NUM_WR_REG; k++)
        if (idx == IDX_W'(k)) shadow_q[k] <= PWDATA;
      wr_idx_q     <= idx[WIDX_W-1:0];
      req_q        <= ~req_q;
      wr_pending_q <= 1'b1;
    end else if (wr_done) begin
      wr_pending_q <= 1'b0;
    end
  end

  logic ack_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_sync_q <= '0;
      status_q   <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
      status_q   <= {status_q[SYNC_STAGES-2:0], data_in};
    end
  end

  assign wr_pending = wr_pending_q;

  // cross_clk domain: reset asserts asynchronously, releases on cross_clk
  logic [SYNC_STAGES-1:0] xrst_q;
  logic                   xresetn;

  always_ff @(posedge cross_clk or negedge resetn) begin
    if (!resetn) xrst_q <= '0;
    else         xrst_q <= {xrst_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign xresetn = xrst_q[SYNC_STAGES-1];

  logic [SYNC_STAGES-1:0]                req_sync_q;
  logic [NUM_WR_REG-1:0][DATA_WIDTH-1:0] data_out_q;
  logic [NUM_WR_REG-1:0]                 data_upd_q;
  logic                                  req_edge;

  assign req_edge = req_sync_q[SYNC_STAGES-1] ^ ack_q;

  // shadow_q/wr_idx_q are held stable by the FSM until this side acknowledges
  always_ff @(posedge cross_clk or negedge xresetn) begin
    if (!xresetn) begin
      req_sync_q <= '0;
      ack_q      <= 1'b0;
      data_out_q <= {NUM_WR_REG{WR_RESET_VAL}};
      data_upd_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
      data_upd_q <= '0;
      if (req_edge) begin
        ack_q <= ~ack_q;
        for (int k = 0; k < NUM_WR_REG; k++) begin
          if (wr_idx_q == WIDX_W'(k)) begin
            data_out_q[k] <= shadow_q[k];
            data_upd_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  assign data_out = data_out_q;
  assign data_upd = data_upd_q;

endmodule

`default_nettype wire
